// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arm_pkg
//  Purpose  : Shared constants and types for the unified memory arbiter.
//             Holds the FSM state encoding, the default timeout and
//             data-burst limits, and the grant-decision type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package arm_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_IBUSY = 2'd1;
  localparam logic [1:0] c_DBUSY = 2'd2;

  // Default limits
  localparam int c_TIMEOUT_DEF = 15;
  localparam int c_MAXDATA_DEF = 2;

  // Outcome of the grant decision taken in IDLE or in a completion cycle
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the fetch port, data port and unified memory port of
//             the arbiter.
//  Ports    : master - arbiter side (takes requests, drives the memory port)
//             slave  - environment side (requesters plus memory)
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int DATA_W = 32
);
  // Fetch port
  logic              IReq;
  logic [DATA_W-1:0] IAddr;
  logic              FlushF;
  logic [DATA_W-1:0] IRdata;
  logic              IValid;
  // Data port
  logic              DReq;
  logic              DWe;
  logic [DATA_W-1:0] DAddr;
  logic [DATA_W-1:0] DWdata;
  logic [DATA_W-1:0] DRdata;
  logic              DValid;
  // Pipeline stalls
  logic              StallF;
  logic              StallM;
  // Unified memory port
  logic              MemReq;
  logic              MemWe;
  logic [DATA_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWdata;
  logic [DATA_W-1:0] MemRdata;
  logic              MemReady;
  // Status
  logic              BusErr;

  modport master (
    input  IReq, IAddr, FlushF, DReq, DWe, DAddr, DWdata, MemRdata, MemReady,
    output IRdata, IValid, DRdata, DValid, StallF, StallM,
           MemReq, MemWe, MemAddr, MemWdata, BusErr
  );

  modport slave (
    output IReq, IAddr, FlushF, DReq, DWe, DAddr, DWdata, MemRdata, MemReady,
    input  IRdata, IValid, DRdata, DValid, StallF, StallM,
           MemReq, MemWe, MemAddr, MemWdata, BusErr
  );

endinterface
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mem_timeout_ctr
//  Purpose  : Counts memory wait cycles of the current transaction and flags
//             the cycle in which the wait budget is used up.
//  Ports    : clk, reset  - clock, asynchronous active-high reset
//             clear       - restart the count (no transaction / completed)
//             enable      - a busy cycle without MemReady
//             expired     - this enabled cycle is the TIMEOUT-th wait cycle
//  Revision : 1.0  initial release
// ============================================================================
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Count only needs to reach TIMEOUT-1; the TIMEOUT-th cycle is flagged
  // combinationally so the requester sees its Valid in that same cycle.
  localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

  logic [c_CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Arbitrates a fetch port and a data port onto one memory port.
//             Data has priority, except that after MAXDATA back-to-back data
//             grants with a fetch waiting, the fetch is served. A transaction
//             that waits TIMEOUT cycles is abandoned with a zero response and
//             a sticky BusErr.
//  Ports    : clk    - clock, rising edge
//             reset  - asynchronous active-high reset
//             bus    - mem_arbiter_if.master (fetch, data and memory ports)
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import arm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = c_TIMEOUT_DEF,
  parameter int MAXDATA = c_MAXDATA_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam int               c_DCW  = (MAXDATA > 0) ? $clog2(MAXDATA + 1) : 1;
  localparam logic [c_DCW-1:0] c_DMAX = c_DCW'(MAXDATA);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_kill;
  logic              r_buserr;
  logic [c_DCW-1:0]  r_dcount;

  logic   w_in_ibusy;
  logic   w_in_dbusy;
  logic   w_busy;
  logic   w_done;
  logic   w_expired;
  logic   w_finish;
  logic   w_window;
  logic   w_tmo_clear;
  logic   w_tmo_en;
  grant_e w_grant;

  assign w_in_ibusy = (r_state == c_IBUSY);
  assign w_in_dbusy = (r_state == c_DBUSY);
  assign w_busy     = w_in_ibusy || w_in_dbusy;
  assign w_done     = w_busy && bus.MemReady;     // MemReady in IDLE is ignored
  assign w_finish   = w_done || w_expired;
  // Grants are only decided when the port is free now or frees at this edge;
  // a timeout always returns to IDLE first.
  assign w_window   = (r_state == c_IDLE) || w_done;

  // --------------------------------------------------------------------------
  // Wait-cycle watchdog
  // --------------------------------------------------------------------------
  assign w_tmo_en    = w_busy && !bus.MemReady;
  assign w_tmo_clear = !w_busy || bus.MemReady || w_expired;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_tmo_clear),
    .enable  (w_tmo_en),
    .expired (w_expired)
  );

  // --------------------------------------------------------------------------
  // Grant decision. A request level seen in a completion cycle is treated as
  // the requester's next request, giving back-to-back transactions.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant = GNT_NONE;
    if (w_window) begin
      if (bus.DReq && !(bus.IReq && (r_dcount >= c_DMAX))) begin
        w_grant = GNT_DATA;
      end else if (bus.IReq) begin
        w_grant = GNT_FETCH;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_expired) begin
      w_state_nxt = c_IDLE;
    end else if (w_window) begin
      case (w_grant)
        GNT_DATA:  w_state_nxt = c_DBUSY;
        GNT_FETCH: w_state_nxt = c_IBUSY;
        default:   w_state_nxt = c_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, latched request and data-burst counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_dcount <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (w_grant)
        GNT_DATA: begin
          r_addr  <= bus.DAddr;
          r_we    <= bus.DWe;
          r_wdata <= bus.DWdata;
          // Only grants that overtake a waiting fetch count towards the limit
          if (bus.IReq) begin
            if (r_dcount != c_DMAX) begin
              r_dcount <= r_dcount + 1'b1;
            end
          end else begin
            r_dcount <= '0;
          end
        end
        GNT_FETCH: begin
          r_addr   <= bus.IAddr;
          r_we     <= 1'b0;
          r_wdata  <= '0;
          r_dcount <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Kill mark: a flush during a fetch (even in its completion cycle) drops
  // that fetch's IValid; the memory access itself still runs to the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kill <= 1'b0;
    end else if (w_in_ibusy) begin
      if (w_finish) begin
        r_kill <= 1'b0;
      end else if (bus.FlushF) begin
        r_kill <= 1'b1;
      end
    end else begin
      r_kill <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buserr <= 1'b0;
    end else if (w_expired) begin
      r_buserr <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.MemReq   = w_busy;
  assign bus.MemWe    = r_we;
  assign bus.MemAddr  = r_addr;
  assign bus.MemWdata = r_wdata;
  assign bus.BusErr   = r_buserr;

  assign bus.IValid = w_in_ibusy && w_finish && !(r_kill || bus.FlushF);
  assign bus.DValid = w_in_dbusy && w_finish;
  // Timed-out transactions return zero
  assign bus.IRdata = (w_in_ibusy && bus.MemReady) ? bus.MemRdata : '0;
  assign bus.DRdata = (w_in_dbusy && bus.MemReady) ? bus.MemRdata : '0;

  assign bus.StallF = bus.IReq && !bus.IValid;
  assign bus.StallM = bus.DReq && !bus.DValid;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Requests are queued into
//             requester models; expected grants and responses go into
//             scoreboard queues that a negedge monitor pops and compares.
//             Memory model: read data = address + 0xE39FFF01.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xact_t;

  logic clk;
  logic reset;

  mem_arbiter_if #(.DATA_W(32)) bus ();

  mem_arbiter #(
    .DATA_W  (32),
    .TIMEOUT (15),
    .MAXDATA (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Requester and scoreboard queues
  logic [31:0] iq[$];
  xact_t       dq[$];
  xact_t       exp_g[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  // Memory model controls
  int mem_wait = 0;
  bit mem_on   = 1'b1;
  int wcnt     = 0;

  // Monitor statistics
  int cyc           = 0;
  int memreq_cycles = 0;
  int stallf_cycles = 0;
  int starts[$];
  bit p_memreq      = 1'b0;
  bit p_done        = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic req_fetch(input logic [31:0] a);
    iq.push_back(a);
  endtask

  task automatic req_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    xact_t x;
    x.we = we; x.addr = a; x.wdata = wd;
    dq.push_back(x);
  endtask

  task automatic exp_grant(input logic we, input logic [31:0] a, input logic [31:0] wd);
    xact_t x;
    x.we = we; x.addr = a; x.wdata = wd;
    exp_g.push_back(x);
  endtask

  // --------------------------------------------------------------------------
  // Memory responder and requester models: +1 after the edge drive MemReady,
  // +2 retire the completing request and present the next one.
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.MemReq && mem_on) begin
        if (wcnt >= mem_wait) begin
          bus.MemReady = 1'b1;
          bus.MemRdata = bus.MemAddr + 32'hE39F_FF01;
          wcnt = 0;
        end else begin
          bus.MemReady = 1'b0;
          bus.MemRdata = '0;
          wcnt++;
        end
      end else begin
        bus.MemReady = 1'b0;
        bus.MemRdata = '0;
        wcnt = 0;
      end
      #1;
      if (bus.DValid) begin
        if (dq.size() != 0) void'(dq.pop_front());
      end else if (bus.IValid || (bus.MemReq && bus.MemReady)) begin
        if (iq.size() != 0) void'(iq.pop_front());
      end
      bus.IReq   = (iq.size() != 0);
      bus.IAddr  = (iq.size() != 0) ? iq[0] : 32'h0;
      bus.DReq   = (dq.size() != 0);
      bus.DWe    = (dq.size() != 0) ? dq[0].we : 1'b0;
      bus.DAddr  = (dq.size() != 0) ? dq[0].addr : 32'h0;
      bus.DWdata = (dq.size() != 0) ? dq[0].wdata : 32'h0;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    xact_t g;
    logic [31:0] e;
    cyc++;
    if (bus.MemReq) memreq_cycles++;
    if (bus.StallF) stallf_cycles++;
    if (bus.IValid) begin
      if (exp_i.size() == 0) check("ivalid_unexpected", {31'h0, bus.IValid}, 32'h0);
      else begin
        e = exp_i.pop_front();
        check("irdata", bus.IRdata, e);
      end
    end
    if (bus.DValid) begin
      if (exp_d.size() == 0) check("dvalid_unexpected", {31'h0, bus.DValid}, 32'h0);
      else begin
        e = exp_d.pop_front();
        check("drdata", bus.DRdata, e);
      end
    end
    if (!reset && bus.MemReq && (!p_memreq || p_done)) begin
      starts.push_back(cyc);
      if (exp_g.size() == 0) check("grant_unexpected", {31'h0, bus.MemReq}, 32'h0);
      else begin
        g = exp_g.pop_front();
        check("grant_we",    {31'h0, bus.MemWe}, {31'h0, g.we});
        check("grant_addr",  bus.MemAddr, g.addr);
        check("grant_wdata", bus.MemWdata, g.wdata);
      end
    end
    p_memreq = bus.MemReq;
    p_done   = (bus.MemReq && bus.MemReady) || bus.IValid || bus.DValid;
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((iq.size() != 0 || dq.size() != 0 || bus.MemReq) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
    end
    @(posedge clk);
    #3;
  endtask

  task automatic wait_memreq(input string name);
    int n;
    n = 0;
    while (!bus.MemReq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_memreq: MemReq 0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic clear_stats();
    memreq_cycles = 0;
    stallf_cycles = 0;
    starts.delete();
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    bus.IReq   = 1'b0; bus.IAddr  = '0; bus.FlushF = 1'b0;
    bus.DReq   = 1'b0; bus.DWe    = 1'b0; bus.DAddr = '0; bus.DWdata = '0;
    bus.MemRdata = '0; bus.MemReady = 1'b0;

    repeat (3) @(posedge clk);
    #3;
    // Reset state
    check("rst_memreq",   {31'h0, bus.MemReq}, 32'h0);
    check("rst_ivalid",   {31'h0, bus.IValid}, 32'h0);
    check("rst_dvalid",   {31'h0, bus.DValid}, 32'h0);
    check("rst_buserr",   {31'h0, bus.BusErr}, 32'h0);
    check("rst_memaddr",  bus.MemAddr, 32'h0);
    check("rst_memwdata", bus.MemWdata, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #3;

    // Single fetch, two wait cycles
    clear_stats();
    mem_wait = 2;
    req_fetch(32'h100);
    exp_grant(1'b0, 32'h100, 32'h0);
    exp_i.push_back(32'hE3A0_0001);
    drain("fetch1");
    check("fetch1_memreq_cycles", memreq_cycles, 32'd3);
    check("fetch1_stallf_cycles", stallf_cycles, 32'd3);

    // Store and fetch together, zero wait: store first, then fetch, no gap
    clear_stats();
    mem_wait = 0;
    req_data(1'b1, 32'h200, 32'hAA);
    req_fetch(32'h104);
    exp_grant(1'b1, 32'h200, 32'hAA);
    exp_grant(1'b0, 32'h104, 32'h0);
    exp_d.push_back(32'hE3A0_0101);
    exp_i.push_back(32'hE3A0_0005);
    drain("store_fetch");
    check("store_fetch_starts", starts.size(), 32'd2);
    if (starts.size() == 2) check("store_fetch_gap", starts[1] - starts[0], 32'd1);
    check("store_fetch_memreq_cycles", memreq_cycles, 32'd2);

    // Continuous data with fetch pending: D, D, I, D, D, I
    mem_wait = 0;
    req_data(1'b0, 32'h300, 32'h0);
    req_data(1'b0, 32'h304, 32'h0);
    req_data(1'b0, 32'h308, 32'h0);
    req_data(1'b0, 32'h30C, 32'h0);
    req_fetch(32'h110);
    req_fetch(32'h114);
    exp_grant(1'b0, 32'h300, 32'h0);
    exp_grant(1'b0, 32'h304, 32'h0);
    exp_grant(1'b0, 32'h110, 32'h0);
    exp_grant(1'b0, 32'h308, 32'h0);
    exp_grant(1'b0, 32'h30C, 32'h0);
    exp_grant(1'b0, 32'h114, 32'h0);
    exp_d.push_back(32'hE3A0_0201);
    exp_d.push_back(32'hE3A0_0205);
    exp_d.push_back(32'hE3A0_0209);
    exp_d.push_back(32'hE3A0_020D);
    exp_i.push_back(32'hE3A0_0011);
    exp_i.push_back(32'hE3A0_0015);
    drain("burst");

    // Flush in the second IBUSY cycle kills that fetch only
    mem_wait = 3;
    req_fetch(32'h120);
    req_fetch(32'h124);
    exp_grant(1'b0, 32'h120, 32'h0);
    exp_grant(1'b0, 32'h124, 32'h0);
    exp_i.push_back(32'hE3A0_0025);
    wait_memreq("flush");
    @(posedge clk); #3; bus.FlushF = 1'b1;
    @(posedge clk); #3; bus.FlushF = 1'b0;
    drain("flush");

    // Flush while idle has no effect on the following fetch
    mem_wait = 1;
    bus.FlushF = 1'b1;
    @(posedge clk); #3; bus.FlushF = 1'b0;
    req_fetch(32'h128);
    exp_grant(1'b0, 32'h128, 32'h0);
    exp_i.push_back(32'hE3A0_0029);
    drain("flush_idle");

    // Memory never ready on a load: timeout after 15 cycles
    clear_stats();
    mem_on = 1'b0;
    req_data(1'b0, 32'h400, 32'h0);
    exp_grant(1'b0, 32'h400, 32'h0);
    exp_d.push_back(32'h0);
    drain("timeout");
    check("timeout_memreq_cycles", memreq_cycles, 32'd15);
    check("timeout_buserr", {31'h0, bus.BusErr}, 32'h1);
    mem_on = 1'b1;
    mem_wait = 0;
    req_fetch(32'h130);
    exp_grant(1'b0, 32'h130, 32'h0);
    exp_i.push_back(32'hE3A0_0031);
    drain("after_timeout");
    check("buserr_sticky", {31'h0, bus.BusErr}, 32'h1);

    // Reset in the middle of a fetch
    mem_wait = 6;
    req_fetch(32'h500);
    exp_grant(1'b0, 32'h500, 32'h0);
    wait_memreq("rst_mid");
    @(posedge clk); #3;
    reset = 1'b1;
    iq.delete();
    bus.IReq = 1'b0;
    #1;
    check("rst_mid_memreq",  {31'h0, bus.MemReq}, 32'h0);
    check("rst_mid_ivalid",  {31'h0, bus.IValid}, 32'h0);
    check("rst_mid_buserr",  {31'h0, bus.BusErr}, 32'h0);
    check("rst_mid_memaddr", bus.MemAddr, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_mid_idle_memreq", {31'h0, bus.MemReq}, 32'h0);

    // Everything expected must have been seen
    check("left_grants", exp_g.size(), 32'd0);
    check("left_iresp",  exp_i.size(), 32'd0);
    check("left_dresp",  exp_d.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
